// File: rtl/carry_select_adder_pkg.sv
// carry_select_adder_pkg
//   Shared defaults for the carry-select adder and the slice-count helper.
//   WIDTH_DEF  : default operand/sum width in bits
//   BLOCK_DEF  : default carry-select slice size in bits
//   NUM_BLOCKS : slice count for the default configuration
package carry_select_adder_pkg;

    localparam int WIDTH_DEF  = 8;
    localparam int BLOCK_DEF  = 4;
    localparam int NUM_BLOCKS = WIDTH_DEF / BLOCK_DEF;

    // Slice count for an arbitrary configuration. The divide-by-zero case
    // is guarded here so a bad BLOCK reports through the parameter check
    // instead of failing inside constant evaluation.
    function automatic int num_blocks(input int width, input int block);
        if (block <= 0) begin
            return 0;
        end
        return width / block;
    endfunction

endpackage

// File: rtl/carry_select_adder_rca_block.sv
// csa_rca_block
//   BLOCK-bit ripple-carry adder built from full-adder equations.
//   Ports:
//     a, b : BLOCK-bit addends
//     cin  : carry into bit 0
//     sum  : BLOCK-bit sum
//     cout : carry out of the top bit
module csa_rca_block
    import carry_select_adder_pkg::*;
#(
    parameter int BLOCK = BLOCK_DEF
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin,
    output logic [BLOCK-1:0] sum,
    output logic             cout
);

    logic [BLOCK:0] carry;

    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = cin;
        for (int i = 0; i < BLOCK; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        cout = carry[BLOCK];
    end

endmodule

// File: rtl/carry_select_adder.sv
// carry_select_adder
//   Registered carry-select adder: {co,S} = a + b + cin.
//   Slice 0 ripples directly from cin; every higher slice precomputes the
//   sums for carry-in 0 and 1 and picks one with the carry selected below it.
//   Ports:
//     clk       : rising-edge clock
//     rst       : synchronous active-high reset
//     in_valid  : operands valid this cycle
//     a, b      : WIDTH-bit unsigned addends
//     cin       : carry-in
//     out_valid : S/co updated by the previous edge
//     S         : registered sum
//     co        : registered carry-out
module carry_select_adder
    import carry_select_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int BLOCK = BLOCK_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] S,
    output logic             co
);

    localparam int NB = num_blocks(WIDTH, BLOCK);

    generate
        if (BLOCK < 1 || WIDTH < BLOCK || (WIDTH % BLOCK) != 0) begin : g_bad_params
            $error("carry_select_adder: WIDTH (%0d) must be a positive multiple of BLOCK (%0d)",
                   WIDTH, BLOCK);
        end
    endgenerate

    logic [WIDTH-1:0] sum_comb;
    logic [NB-1:0]    cout0;     // per-slice carry-out assuming carry-in 0
    logic [NB-1:0]    cout1;     // per-slice carry-out assuming carry-in 1
    logic [NB:0]      sel_c;     // selected carry into each slice

    genvar k;
    generate
        for (k = 0; k < NB; k++) begin : g_slice
            if (k == 0) begin : g_lo
                csa_rca_block #(.BLOCK(BLOCK)) u_rca (
                    .a    (a[BLOCK-1:0]),
                    .b    (b[BLOCK-1:0]),
                    .cin  (cin),
                    .sum  (sum_comb[BLOCK-1:0]),
                    .cout (cout0[0])
                );
                // Slice 0 has one real carry; both candidates are the same so
                // the shared select chain below passes it straight through.
                assign cout1[0] = cout0[0];
            end else begin : g_hi
                logic [BLOCK-1:0] s0;
                logic [BLOCK-1:0] s1;

                csa_rca_block #(.BLOCK(BLOCK)) u_rca0 (
                    .a    (a[k*BLOCK +: BLOCK]),
                    .b    (b[k*BLOCK +: BLOCK]),
                    .cin  (1'b0),
                    .sum  (s0),
                    .cout (cout0[k])
                );
                csa_rca_block #(.BLOCK(BLOCK)) u_rca1 (
                    .a    (a[k*BLOCK +: BLOCK]),
                    .b    (b[k*BLOCK +: BLOCK]),
                    .cin  (1'b1),
                    .sum  (s1),
                    .cout (cout1[k])
                );

                assign sum_comb[k*BLOCK +: BLOCK] = sel_c[k] ? s1 : s0;
            end
        end
    endgenerate

    // Carry select chain kept in one process so the slice-to-slice
    // dependency is not seen as a loop on a single vector.
    always_comb begin
        sel_c    = '0;
        sel_c[0] = cin;
        for (int i = 0; i < NB; i++) begin
            sel_c[i + 1] = sel_c[i] ? cout1[i] : cout0[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            S         <= '0;
            co        <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                S  <= sum_comb;
                co <= sel_c[NB];
            end
        end
    end

endmodule

// File: tb/tb_carry_select_adder.sv
module tb_carry_select_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        cin;
    logic [7:0]  a8, b8;
    logic [15:0] a16, b16;
    logic        out_valid8, out_valid16;
    logic [7:0]  s8;
    logic [15:0] s16;
    logic        co8, co16;

    int total = 0;
    int bad   = 0;

    // reference state: what the outputs should show after the last edge
    int ref8  = 0;
    int ref16 = 0;
    logic ref_ov = 1'b0;

    always #5 clk = ~clk;

    carry_select_adder dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a8),
        .b         (b8),
        .cin       (cin),
        .out_valid (out_valid8),
        .S         (s8),
        .co        (co8)
    );

    carry_select_adder #(.WIDTH(16), .BLOCK(4)) dut16 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a16),
        .b         (b16),
        .cin       (cin),
        .out_valid (out_valid16),
        .S         (s16),
        .co        (co16)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the reference model at the edge,
    // then compare both instances one time unit later.
    task automatic tick(input logic r, input logic v, input logic [15:0] xa16,
                        input logic [15:0] xb16, input logic [7:0] xa8,
                        input logic [7:0] xb8, input logic c, input string tag);
        rst      = r;
        in_valid = v;
        a16      = xa16;
        b16      = xb16;
        a8       = xa8;
        b8       = xb8;
        cin      = c;
        @(posedge clk);
        if (r) begin
            ref8   = 0;
            ref16  = 0;
            ref_ov = 1'b0;
        end else begin
            ref_ov = v;
            if (v) begin
                ref8  = (int'(xa8) + int'(xb8) + int'(c)) % 512;
                ref16 = (int'(xa16) + int'(xb16) + int'(c)) % 131072;
            end
        end
        #1;
        chk({tag, ".ov8"},  32'(out_valid8),  32'(ref_ov));
        chk({tag, ".s8"},   32'(s8),          32'(ref8 % 256));
        chk({tag, ".co8"},  32'(co8),         32'(ref8 / 256));
        chk({tag, ".ov16"}, 32'(out_valid16), 32'(ref_ov));
        chk({tag, ".s16"},  32'(s16),         32'(ref16 % 65536));
        chk({tag, ".co16"}, 32'(co16),        32'(ref16 / 65536));
    endtask

    task automatic tick8(input logic v, input logic [7:0] xa, input logic [7:0] xb,
                         input logic c, input string tag);
        tick(1'b0, v, {8'h00, xa}, {8'h00, xb}, xa, xb, c, tag);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; cin = 1'b0;
        a8 = '0; b8 = '0; a16 = '0; b16 = '0;

        tick(1'b1, 1'b0, 16'h0, 16'h0, 8'h0, 8'h0, 1'b0, "reset");
        tick(1'b1, 1'b1, 16'hffff, 16'hffff, 8'hff, 8'hff, 1'b1, "reset_with_valid");

        // directed vectors, 8-bit values mirrored into the 16-bit instance
        tick8(1'b1, 8'h06, 8'h06, 1'b0, "six_plus_six");
        chk("six_plus_six.const_s8", 32'(s8), 32'h0C);
        tick8(1'b1, 8'h0E, 8'h07, 1'b0, "b2b_first");
        chk("b2b_first.const_s8", 32'(s8), 32'h15);
        tick8(1'b1, 8'h02, 8'h09, 1'b0, "b2b_second");
        chk("b2b_second.const_s8", 32'(s8), 32'h0B);
        tick8(1'b1, 8'hFF, 8'h01, 1'b0, "ff_plus_1");
        chk("ff_plus_1.const_co8", 32'(co8), 32'h1);
        tick8(1'b1, 8'hFF, 8'hFF, 1'b1, "all_ones");
        chk("all_ones.const_s8", 32'(s8), 32'hFF);
        tick8(1'b1, 8'h0F, 8'h00, 1'b1, "slice0_carry");
        chk("slice0_carry.const_s8", 32'(s8), 32'h10);
        tick8(1'b1, 8'hF0, 8'h10, 1'b0, "top_carry");
        chk("top_carry.const_co8", 32'(co8), 32'h1);
        tick8(1'b0, 8'h12, 8'h34, 1'b1, "hold");
        tick8(1'b1, 8'h00, 8'h00, 1'b0, "all_zero");

        // 16-bit boundary cases
        tick(1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 8'hFF, 8'hFF, 1'b1, "w16_all_ones");
        tick(1'b0, 1'b1, 16'h0FFF, 16'h0001, 8'h0F, 8'h01, 1'b0, "w16_chain");

        // reset beats a same-cycle valid, then idle holds the zeros
        tick(1'b1, 1'b1, 16'h0055, 16'h0033, 8'h55, 8'h33, 1'b0, "rst_vs_valid");
        tick8(1'b0, 8'h55, 8'h33, 1'b0, "idle_after_rst");

        // pending result discarded by reset
        tick8(1'b1, 8'h21, 8'h43, 1'b0, "pending");
        tick(1'b1, 1'b0, 16'h0, 16'h0, 8'h0, 8'h0, 1'b0, "pending_rst");
        tick8(1'b0, 8'h00, 8'h00, 1'b0, "no_pulse");
        tick8(1'b1, 8'h80, 8'h80, 1'b0, "first_after_rst");

        for (int n = 0; n < 10000; n++) begin
            logic [15:0] ra, rb;
            ra = 16'($urandom);
            rb = 16'($urandom);
            tick(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) != 0),
                 ra, rb, 8'($urandom), 8'($urandom), 1'($urandom), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/carry_select_adder.md
CARRY_SELECT_ADDER -- requirements
Module: carry_select_adder

Interface
REQ-001 The block SHALL have these parameters:
- WIDTH, default 8, operand/sum width in bits.
- BLOCK, default 4, carry-select block size in bits.
REQ-002 The block SHALL have these ports, one clock, reset synchronous and active-high:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operands valid this cycle
- a  input  WIDTH  addend A, unsigned
- b  input  WIDTH  addend B, unsigned
- cin  input  1  carry-in
- out_valid  output  1  S/co valid
- S  output  WIDTH  registered sum
- co  output  1  registered carry-out

Function
REQ-003 The block SHALL compute {co,S} = a + b + cin, modulo 2^(WIDTH+1), with no loss of carry.
REQ-004 The lowest BLOCK bits SHALL be summed by a single ripple-carry block driven by cin.
REQ-005 Each higher BLOCK-bit slice SHALL compute two sums in parallel (carry-in 0 and carry-in 1) and select sum and carry by the previous slice's selected carry-out.
REQ-006 co SHALL be the selected carry-out of the most significant slice.
REQ-007 Outputs SHALL be registered with latency exactly 1 cycle: values sampled at edge N with in_valid=1 appear on S/co with out_valid=1 after edge N.
REQ-008 When in_valid=0 at an edge, S and co SHALL hold their previous values, and out_valid SHALL be 0 after that edge.
REQ-009 Back-to-back in_valid=1 SHALL be accepted every cycle with no stall; no back-pressure exists.
REQ-010 X/Z-free operands SHALL yield X-free outputs; no internal state exists beyond the output registers.
REQ-011 WIDTH SHALL be a positive multiple of BLOCK; any other combination SHALL cause an elaboration-time error.
REQ-012 Boundary: all-ones + all-ones + 1 SHALL give S=all-ones, co=1; all-zero inputs with cin=0 SHALL give S=0, co=0.

Reset
REQ-013 When rst=1 at a rising edge, S, co and out_valid SHALL all be 0 after that edge, regardless of in_valid.
REQ-014 rst SHALL take priority over in_valid in the same cycle; the first result after rst deasserts appears 1 cycle after the first accepted in_valid.
REQ-015 Reset asserted with a result pending SHALL discard that result; out_valid SHALL not pulse for it.

Structure
REQ-016 A shared package carry_select_adder_pkg SHALL hold the WIDTH/BLOCK defaults and the derived constant NUM_BLOCKS = WIDTH/BLOCK.
REQ-017 One sub-module, csa_rca_block, SHALL be used. It is a BLOCK-bit ripple-carry adder with inputs (a, b, cin) and outputs (sum, cout), built from full-adder equations.
REQ-018 The top level SHALL instantiate csa_rca_block:
- once for slice 0;
- twice for each higher slice (cin tied to 0 and to 1);
- with selection muxes in a generate loop.

Verification
REQ-019 a=0x06, b=0x06, cin=0, in_valid=1 -> next cycle S=0x0C, co=0, out_valid=1.
REQ-020 a=0x0E, b=0x07, cin=0 -> S=0x15, co=0; then a=0x02, b=0x09, cin=0 on the next cycle -> S=0x0B, co=0 one cycle later.
REQ-021 a=0xFF, b=0x01, cin=0 -> S=0x00, co=1 (carry propagates across the slice boundary); a=0xFF, b=0xFF, cin=1 -> S=0xFF, co=1.
REQ-022 a=0x0F, b=0x00, cin=1 -> S=0x10, co=0 (slice-0 carry selects the upper sum); a=0xF0, b=0x10, cin=0 -> S=0x00, co=1.
REQ-023 in_valid=1 with a=0x55, b=0x33 and rst=1 in the same cycle -> S=0, co=0, out_valid=0; then in_valid=0 for one cycle -> out_valid=0 and S/co held.
REQ-024 Random sweep of 10,000 vectors, including WIDTH=16 with BLOCK=4 -> {co,S} matches a+b+cin every accepted cycle.
